reg_file_dumper: RTL
====================

# reg_file_dumper

Sequential debug reader for the 8 × 8-bit CPU register file. On a START pulse it walks register addresses 0 to NUM_REGS-1 through one register-file read port. For each register it waits a fixed settle time, captures the data and presents it as an {address, data} word on a valid/ready stream. It sits beside the CPU datapath, driving one read-address input of reg_file. Its stream output feeds the trace/monitor logic used in simulation and FPGA bring-up.

## Interface
- NUM_REGS, 8: number of registers dumped; addresses 0..NUM_REGS-1.
- ADDR_WIDTH, 3: register address width; 2^ADDR_WIDTH ≥ NUM_REGS.
- DATA_WIDTH, 8: register data width.
- READ_WAIT, 3: cycles between driving RF_ADDR and sampling RF_DATA; legal range ≥ 1; covers reg_file read delay.
- CLK  in  1  single clock; all state changes on posedge CLK.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin a dump; sampled only in IDLE.
- ABORT  in  1  terminate a dump in progress.
- RF_ADDR  out  ADDR_WIDTH  read address to reg_file read port.
- RF_DATA  in  DATA_WIDTH  read data from reg_file for RF_ADDR.
- DATA_OUT  out  DATA_WIDTH  captured register value.
- ADDR_OUT  out  ADDR_WIDTH  address of DATA_OUT.
- VALID  out  1  DATA_OUT/ADDR_OUT hold a word.
- READY  in  1  consumer accepts the word.
- BUSY  out  1  dump in progress.
- DONE  out  1  one-cycle pulse after the final register is accepted.

## Operation
- Clock is CLK. Reset is synchronous and active-high on RESET: at a posedge with RESET=1 every register clears.
  - Reset values: RF_ADDR=0, DATA_OUT=0, ADDR_OUT=0, VALID=0, BUSY=0, DONE=0, state IDLE, wait counter=0.
  - RESET overrides START, ABORT and READY in the same cycle.
- States: IDLE, WAIT, PRESENT.
- IDLE → WAIT on START=1:
  - RF_ADDR←0, wait counter←READ_WAIT-1, BUSY←1.
- WAIT:
  - While counter≠0: counter←counter-1.
  - When counter=0: DATA_OUT←RF_DATA, ADDR_OUT←RF_ADDR, VALID←1, → PRESENT.
- PRESENT, holding VALID:
  - DATA_OUT and ADDR_OUT are frozen; RF_DATA changes are ignored.
  - Transfer occurs at a posedge with VALID=1 and READY=1.
  - On transfer, if RF_ADDR≠NUM_REGS-1: VALID←0, RF_ADDR←RF_ADDR+1, counter←READ_WAIT-1, → WAIT.
  - On transfer, if RF_ADDR=NUM_REGS-1: VALID←0, BUSY←0, DONE←1, → IDLE.
- DONE returns to 0 on the following posedge unless set again.
- START while BUSY=1 is ignored.
- START on the same edge that DONE is set is ignored; START is sampled only when the registered state is IDLE.
- ABORT=1 in WAIT or PRESENT → IDLE:
  - VALID←0, BUSY←0, DONE stays 0.
  - RF_ADDR, DATA_OUT and ADDR_OUT hold their last values.
- ABORT coincident with a transfer: ABORT wins the state, the word counts as delivered, and DONE is not pulsed. ABORT in IDLE has no effect.
- READY is ignored while VALID=0.
- Address arithmetic: increment only below NUM_REGS-1, so RF_ADDR never wraps.
- The block never writes reg_file.

## Timing
- START sampled at edge k: BUSY=1 and RF_ADDR=0 from edge k.
- VALID for address 0 rises at edge k+READ_WAIT.
- Per-register period with READY held high: READ_WAIT+1 cycles.
  - Transfers occur at edges k+READ_WAIT+1+n·(READ_WAIT+1), n=0..NUM_REGS-1.
- Final transfer at edge k+NUM_REGS·(READ_WAIT+1):
  - BUSY falls and DONE rises at that edge; DONE lasts one cycle.
  - With defaults, this is edge k+32.
- RF_DATA is sampled exactly READ_WAIT cycles after RF_ADDR changes.
- Back-to-back dumps: the earliest accepted START is in the cycle after DONE is high.
- READY stalls add cycles one-for-one; no data loss and no output change while stalled.

## Test plan
- Registers preloaded 10,20,…,80; READY=1; START pulse at edge k → eight words (addr n, data 10·(n+1)) at edges k+4+4n; DONE at edge k+32 for one cycle; BUSY high for 32 cycles.
- READY low for 5 cycles while word addr 2 is valid; RF_DATA forced to 0xFF during the stall → DATA_OUT stays 30, ADDR_OUT=2; transfer on the first READY=1 edge; total dump 5 cycles longer.
- START re-pulsed at addr 4 during a dump → ignored; addresses continue 5,6,7; exactly one DONE.
- ABORT while presenting addr 3 with READY=0 → next edge VALID=0, BUSY=0, no DONE; a new START then restarts at addr 0.
- RESET asserted while in WAIT for addr 5 → next edge all outputs at reset values; START and READY held high during reset cause no activity.
- READ_WAIT=1 build, READY=1 → one word every 2 cycles; DONE at edge k+16; RF_DATA sampled 1 cycle after each RF_ADDR change.

Source files
------------

// File: rtl/reg_file_dumper.sv
// Sequential debug reader: walks register-file addresses 0..NUM_REGS-1 through one
// read port and streams each captured {address, data} pair on a valid/ready output.
module reg_file_dumper #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int READ_WAIT  = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  ABORT,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    input  logic [DATA_WIDTH-1:0] RF_DATA,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [ADDR_WIDTH-1:0] ADDR_OUT,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [1:0]            DBG_STATE
);

    localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(READ_WAIT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign DBG_STATE = state;

    // Stream handshake: a word transfers at a posedge where VALID=1 and READY=1.
    // Once VALID rises, DATA_OUT/ADDR_OUT stay frozen until that transfer (or ABORT).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            RF_ADDR  <= '0;
            DATA_OUT <= '0;
            ADDR_OUT <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        RF_ADDR  <= '0;
                        wait_cnt <= CNT_LOAD;
                        BUSY     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ABORT) begin
                        VALID <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        DATA_OUT <= RF_DATA;
                        ADDR_OUT <= RF_ADDR;
                        VALID    <= 1'b1;
                        state    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    // ABORT wins the state even if READY would have completed the dump.
                    if (ABORT) begin
                        VALID <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else if (READY) begin
                        VALID <= 1'b0;
                        if (RF_ADDR == LAST_ADDR) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            RF_ADDR  <= RF_ADDR + 1'b1;
                            wait_cnt <= CNT_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                default: begin
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
